key_scan_scheduler: RTL and testbench

- Shares one debounce timer among NUM_KEYS push-button inputs and emits a one-cycle press pulse per key.
- Replaces per-key debounce instances on the board-level control path.
- Grants the timer to pending keys in round-robin order.
- Its outputs drive start/change style control pulses into the downstream mode logic.

---
 rtl/key_pkg.sv | 17 +
 rtl/key_sync_2ff.sv | 29 ++
 rtl/key_scan_scheduler.sv | 127 ++++++++++++
 tb/tb_key_scan_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_pkg : shared state encoding and defaults for key scanning     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package key_pkg;

    localparam int DEBOUNCE_CNT_100M = 50000;

    typedef logic [1:0] key_state_t;

    localparam key_state_t ST_IDLE    = 2'd0;
    localparam key_state_t ST_SETTLE  = 2'd1;
    localparam key_state_t ST_CONFIRM = 2'd2;

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_sync_2ff.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_sync_2ff : two-flop synchronizer for one asynchronous input   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module key_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule : key_sync_2ff
`default_nettype wire

// File: rtl/key_scan_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_scan_scheduler : one shared debounce timer, round-robin grant |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module key_scan_scheduler
    import key_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_100M,
    parameter int CNT_W        = 18,
    parameter int ID_W         = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic                busy,
    output logic [ID_W-1:0]     active_id
);

    localparam logic [CNT_W-1:0] C_TIMER_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [ID_W-1:0]  C_LAST_ID    = ID_W'(NUM_KEYS - 1);

    logic [NUM_KEYS-1:0] ks;
    logic [NUM_KEYS-1:0] candidate;
    logic [ID_W:0]       pick;

    key_state_t          state_q,     state_d;
    logic [CNT_W-1:0]    timer_q,     timer_d;
    logic [ID_W-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [ID_W-1:0]     active_id_q, active_id_d;
    logic [NUM_KEYS-1:0] held_q,      held_d;
    logic [NUM_KEYS-1:0] pulse_q,     pulse_d;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_sync
            key_sync_2ff u_sync (
                .clk     (clk),
                .rst_n   (rst_n),
                .async_i (key_in[gi]),
                .sync_o  (ks[gi])
            );
        end
    endgenerate

    // Returns {found, index}: first request at or after ptr, wrapping.
    function automatic logic [ID_W:0] rr_pick(
        input logic [NUM_KEYS-1:0] req,
        input logic [ID_W-1:0]     ptr
    );
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_KEYS;
            if (req[ID_W'(idx)]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    assign candidate = ks & ~held_q;
    assign pick      = rr_pick(candidate, rr_ptr_q);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rr_ptr_d    = rr_ptr_q;
        active_id_d = active_id_q;
        held_d      = held_q & ks;
        pulse_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick[ID_W]) begin
                    active_id_d = pick[ID_W-1:0];
                    timer_d     = '0;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_q == C_TIMER_LAST) begin
                    state_d = ST_CONFIRM;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_CONFIRM: begin
                // A key that released during SETTLE is dropped here without a pulse.
                if (ks[active_id_q]) begin
                    pulse_d[active_id_q] = 1'b1;
                    held_d[active_id_q]  = 1'b1;
                end
                rr_ptr_d = (active_id_q == C_LAST_ID) ? '0 : active_id_q + ID_W'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            rr_ptr_q    <= '0;
            active_id_q <= '0;
            held_q      <= '0;
            pulse_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rr_ptr_q    <= rr_ptr_d;
            active_id_q <= active_id_d;
            held_q      <= held_d;
            pulse_q     <= pulse_d;
        end
    end

    assign key_pulse = pulse_q;
    assign busy      = (state_q != ST_IDLE);
    assign active_id = active_id_q;

endmodule : key_scan_scheduler
`default_nettype wire

// File: tb/tb_key_scan_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_key_scan_scheduler : directed self-checking bench              |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_key_scan_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_a;
    logic [3:0] pulse_a;
    logic       busy_a;
    logic [1:0] aid_a;
    logic [3:0] key_b;
    logic [3:0] pulse_b;
    logic       busy_b;
    logic [1:0] aid_b;

    int n_checks = 0;
    int n_errors = 0;
    int onehot_viol = 0;
    int peak_b = 0;

    logic [1:0] aid_log [0:63];
    logic       bsy_log [0:63];
    int         pe [0:7];
    logic [3:0] pv [0:7];
    int         np;

    key_scan_scheduler #(
        .NUM_KEYS(4), .DEBOUNCE_CNT(8), .CNT_W(4), .ID_W(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .key_in(key_a),
        .key_pulse(pulse_a), .busy(busy_a), .active_id(aid_a)
    );

    key_scan_scheduler dut_b (
        .clk(clk), .rst_n(rst_n), .key_in(key_b),
        .key_pulse(pulse_b), .busy(busy_b), .active_id(aid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(pulse_a) > 1) onehot_viol++;
        if (int'(dut_b.timer_q) > peak_b) peak_b = int'(dut_b.timer_q);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        np = 0;
        for (int i = 0; i < 8; i++) begin
            pe[i] = -1;
            pv[i] = '0;
        end
    endtask

    // Index e of the log corresponds to the negedge after posedge e of the window.
    task automatic observe(input int n);
        for (int e = 0; e < n; e++) begin
            @(negedge clk);
            if (e < 64) begin
                aid_log[e] = aid_a;
                bsy_log[e] = busy_a;
            end
            if (pulse_a != 0 && np < 8) begin
                pe[np] = e;
                pv[np] = pulse_a;
                np++;
            end
        end
    endtask

    task automatic wait_pulse(input bit sel_b, input int max_cyc, output int edge_idx, output logic [3:0] val);
        edge_idx = -1;
        val      = '0;
        for (int e = 0; e < max_cyc; e++) begin
            @(negedge clk);
            if (!sel_b && pulse_a != 0) begin
                edge_idx = e;
                val      = pulse_a;
                break;
            end
            if (sel_b && pulse_b != 0) begin
                edge_idx = e;
                val      = pulse_b;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        key_a = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int         ed;
        logic [3:0] v;
        int         bad;
        logic [3:0] exp_seq [0:3];

        rst_n = 1'b0;
        key_a = '0;
        key_b = '0;
        repeat (2) @(negedge clk);
        check_value("reset_pulse", {28'd0, pulse_a}, 0);
        check_value("reset_busy", {31'd0, busy_a}, 0);
        check_value("reset_aid", {30'd0, aid_a}, 0);
        check_value("reset_busy_b", {31'd0, busy_b}, 0);
        rst_n = 1'b1;

        // Single press on key 0
        key_a = 4'b0001;
        clear_obs();
        observe(40);
        check_value("single_npulse", np, 1);
        check_value("single_edge", pe[0], 11);
        check_value("single_val", {28'd0, pv[0]}, 1);
        check_value("single_busy_e1", {31'd0, bsy_log[1]}, 0);
        check_value("single_busy_e2", {31'd0, bsy_log[2]}, 1);
        check_value("single_busy_e10", {31'd0, bsy_log[10]}, 1);
        check_value("single_busy_e11", {31'd0, bsy_log[11]}, 0);
        check_value("single_aid", {30'd0, aid_log[5]}, 0);

        // Glitch on key 2 while key 0 stays held
        key_a = 4'b0101;
        clear_obs();
        observe(5);
        check_value("glitch_busy_e2", {31'd0, bsy_log[2]}, 1);
        check_value("glitch_aid", {30'd0, aid_log[3]}, 2);
        key_a = 4'b0001;
        observe(20);
        check_value("glitch_npulse", np, 0);
        check_value("glitch_busy_e10", {31'd0, bsy_log[5]}, 1);
        check_value("glitch_busy_e11", {31'd0, bsy_log[6]}, 0);

        // Pointer now at 3: keys 1 and 3 together must serve 3 first
        key_a = 4'b1011;
        clear_obs();
        observe(30);
        check_value("rr_npulse", np, 2);
        check_value("rr_first_val", {28'd0, pv[0]}, 8);
        check_value("rr_first_edge", pe[0], 11);
        check_value("rr_second_val", {28'd0, pv[1]}, 2);
        check_value("rr_second_edge", pe[1], 21);

        // Simultaneous press from reset
        do_reset();
        key_a = 4'b0110;
        clear_obs();
        observe(30);
        check_value("simul_npulse", np, 2);
        check_value("simul_first_val", {28'd0, pv[0]}, 2);
        check_value("simul_first_edge", pe[0], 11);
        check_value("simul_second_val", {28'd0, pv[1]}, 4);
        check_value("simul_second_edge", pe[1], 21);
        check_value("simul_aid_first", {30'd0, aid_log[5]}, 1);
        check_value("simul_aid_second", {30'd0, aid_log[15]}, 2);

        // Fairness between keys 0 and 3
        do_reset();
        key_a = 4'b1001;
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b1000;
        exp_seq[2] = 4'b0001; exp_seq[3] = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            wait_pulse(1'b0, 40, ed, v);
            check_value($sformatf("fair_%0d", k), {28'd0, v}, {28'd0, exp_seq[k]});
            key_a = key_a & ~v;
            repeat (4) @(negedge clk);
            key_a = key_a | v;
        end

        // Release and re-press
        do_reset();
        key_a = 4'b0001;
        wait_pulse(1'b0, 40, ed, v);
        check_value("repress_first_edge", ed, 11);
        key_a = 4'b0000;
        repeat (4) @(negedge clk);
        key_a = 4'b0001;
        wait_pulse(1'b0, 40, ed, v);
        check_value("repress_second_edge", ed, 11);
        check_value("repress_second_val", {28'd0, v}, 1);

        // Asynchronous reset in the middle of SETTLE
        do_reset();
        key_a = 4'b0001;
        repeat (7) @(negedge clk);
        check_value("midrst_timer", {28'd0, dut_a.timer_q}, 4);
        check_value("midrst_busy_before", {31'd0, busy_a}, 1);
        #1 rst_n = 1'b0;
        #1;
        check_value("midrst_busy_async", {31'd0, busy_a}, 0);
        check_value("midrst_timer_async", {28'd0, dut_a.timer_q}, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (pulse_a != 0 || busy_a) bad++;
        end
        check_value("midrst_quiet", bad, 0);
        rst_n = 1'b1;
        wait_pulse(1'b0, 40, ed, v);
        check_value("midrst_restart_edge", ed, 11);
        check_value("midrst_restart_val", {28'd0, v}, 1);

        check_value("onehot", onehot_viol, 0);

        // Default-parameter instance: single press
        key_b = 4'b0001;
        wait_pulse(1'b1, 50100, ed, v);
        check_value("default_edge", ed, 50003);
        check_value("default_val", {28'd0, v}, 1);
        check_value("default_timer_peak", peak_b, 49999);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_key_scan_scheduler
`default_nettype wire
